// File: rtl/for_loop_pkg.sv
// Shared types for the bit-serial reduction engine: operation modes, FSM states
// and the index-width helper used to size counters and bit indices.
package for_loop_pkg;

    typedef enum logic [1:0] {
        MODE_POPCNT = 2'b00,
        MODE_FFS    = 2'b01,
        MODE_REV    = 2'b10,
        MODE_PAR    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bits needed to index n items, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/for_loop_slice.sv
// Combinational step: folds one STEP-bit slice of the operand into the running
// accumulator for the selected mode, and tracks whether any set bit was seen.
module for_loop_slice
    import for_loop_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 1,
    parameter int IW    = 2
) (
    input  logic [STEP-1:0]  bits_i,
    input  logic [IW-1:0]    base_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic             seen_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             seen_o
);

    localparam logic [IW-1:0] MAX_IDX = IW'(WIDTH - 1);

    logic [IW-1:0] pos;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        acc_o  = acc_i;
        seen_o = seen_i;
        pos    = '0;
        for (int j = 0; j < STEP; j++) begin
            pos = base_i + IW'(j);
            case (mode_i)
                MODE_POPCNT: acc_o = acc_o + WIDTH'(bits_i[j]);
                // Slices arrive lowest-first, so the first set bit seen wins.
                MODE_FFS:    if (!seen_o && bits_i[j]) acc_o = WIDTH'(pos);
                MODE_REV:    acc_o[MAX_IDX - pos] = bits_i[j];
                MODE_PAR:    acc_o[0] = acc_o[0] ^ bits_i[j];
                default:     acc_o = acc_o;
            endcase
            seen_o = seen_o | bits_i[j];
        end
    end

endmodule

// File: rtl/for_loop_seq.sv
// Sequential bit-serial engine: accepts an operand in IDLE, walks it STEP bits
// per cycle in RUN, and holds the result in DONE until the consumer takes it.
module for_loop_seq
    import for_loop_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    if (WIDTH < 1 || WIDTH > 64 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
        $error("for_loop_seq: WIDTH must be 1..64 and divisible by STEP");
    end

    localparam int            NSTEP = WIDTH / STEP;
    localparam int            CW    = idx_width(NSTEP);
    localparam int            IW    = idx_width(WIDTH);
    localparam logic [CW-1:0] LAST  = CW'(NSTEP - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [1:0]       mode_q,  mode_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             seen_q,  seen_d;

    logic [IW-1:0]    slice_base;
    logic [STEP-1:0]  slice_bits;
    logic [WIDTH-1:0] slice_acc;
    logic             slice_seen;

    assign slice_base = IW'(cnt_q * STEP);
    assign slice_bits = data_q[slice_base +: STEP];

    for_loop_slice #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .IW    (IW)
    ) u_slice (
        .bits_i (slice_bits),
        .base_i (slice_base),
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .seen_i (seen_q),
        .acc_o  (slice_acc),
        .seen_o (slice_seen)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    acc_d   = '0;
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d  = slice_acc;
                seen_d = slice_seen;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; all state, data included, is cleared so outputs read zero after reset.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            acc_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign out_zero  = (state_q == ST_DONE) && !seen_q;

endmodule

// File: tb/tb_for_loop_seq.sv
// Directed bench: WIDTH=4/STEP=1 vectors with hand-computed results, reset and
// backpressure cases, plus a full operand sweep of a WIDTH=8/STEP=2 instance.
module tb_for_loop_seq;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_zero4;
    logic [3:0] in_data4, out_data4;
    logic [1:0] in_mode4;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
    logic [7:0] in_data8, out_data8;
    logic [1:0] in_mode8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for_loop_seq #(.WIDTH(4), .STEP(1)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .in_mode   (in_mode4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_zero  (out_zero4)
    );

    for_loop_seq #(.WIDTH(8), .STEP(2)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_mode   (in_mode8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_zero  (out_zero8)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_res(input logic [7:0] d, input logic [1:0] m, input int w);
        logic [7:0] r;
        r = '0;
        case (m)
            2'd0: for (int i = 0; i < w; i++) r = r + 8'(d[i]);
            2'd1: for (int i = w - 1; i >= 0; i--) if (d[i]) r = 8'(i);
            2'd2: for (int i = 0; i < w; i++) r[i] = d[w-1-i];
            default: for (int i = 0; i < w; i++) r[0] = r[0] ^ d[i];
        endcase
        return r;
    endfunction

    task automatic drive_in(input bit wide, input logic v, input logic [7:0] d, input logic [1:0] m);
        if (wide) begin
            in_valid8 = v; in_data8 = d; in_mode8 = m;
        end else begin
            in_valid4 = v; in_data4 = d[3:0]; in_mode4 = m;
        end
    endtask

    task automatic set_ready(input bit wide, input logic r);
        if (wide) out_ready8 = r;
        else      out_ready4 = r;
    endtask

    task automatic do_op(input bit wide, input logic [7:0] d, input logic [1:0] m,
                         input logic [7:0] exp_d, input logic exp_z, input int hold,
                         input string tag);
        int lat;
        check({tag, " in_ready"}, 8'(wide ? in_ready8 : in_ready4), 8'd1);
        drive_in(wide, 1'b1, d, m);
        @(posedge clk); #1;
        lat = 0;
        // Garbage offered throughout RUN must not disturb the result.
        while (!(wide ? out_valid8 : out_valid4) && lat < 20) begin
            drive_in(wide, 1'b1, 8'($urandom), 2'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        drive_in(wide, 1'b0, 8'h00, 2'd0);
        check({tag, " latency"}, 8'(lat), wide ? 8'd4 : 8'd4);
        check({tag, " data"}, wide ? out_data8 : {4'h0, out_data4}, exp_d);
        check({tag, " zero"}, 8'(wide ? out_zero8 : out_zero4), 8'(exp_z));
        for (int h = 0; h < hold; h++) begin
            drive_in(wide, 1'b1, 8'($urandom), 2'($urandom));
            @(posedge clk); #1;
            check({tag, " hold data"}, wide ? out_data8 : {4'h0, out_data4}, exp_d);
            check({tag, " hold in_ready"}, 8'(wide ? in_ready8 : in_ready4), 8'd0);
            check({tag, " hold out_valid"}, 8'(wide ? out_valid8 : out_valid4), 8'd1);
        end
        drive_in(wide, 1'b0, 8'h00, 2'd0);
        set_ready(wide, 1'b1);
        @(posedge clk); #1;
        set_ready(wide, 1'b0);
        check({tag, " back in_ready"}, 8'(wide ? in_ready8 : in_ready4), 8'd1);
        check({tag, " back out_valid"}, 8'(wide ? out_valid8 : out_valid4), 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid4 = 1'b0; in_data4 = '0; in_mode4 = '0; out_ready4 = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; in_mode8 = '0; out_ready8 = 1'b0;
        // in_valid offered during reset must not be taken.
        in_valid4 = 1'b1; in_data4 = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready4",  8'(in_ready4),  8'd1);
        check("rst out_valid4", 8'(out_valid4), 8'd0);
        check("rst out_data4",  {4'h0, out_data4}, 8'h00);
        check("rst out_zero4",  8'(out_zero4),  8'd0);
        check("rst in_ready8",  8'(in_ready8),  8'd1);
        check("rst out_valid8", 8'(out_valid8), 8'd0);
        check("rst out_data8",  out_data8,      8'h00);
        in_valid4 = 1'b0; in_data4 = '0;
        rst_n = 1'b1;

        do_op(1'b0, 8'h0B, 2'd0, 8'd3, 1'b0, 0, "pop1011");
        do_op(1'b0, 8'h08, 2'd1, 8'd3, 1'b0, 0, "ffs1000");
        do_op(1'b0, 8'h00, 2'd1, 8'd0, 1'b1, 0, "ffs0000");
        do_op(1'b0, 8'h01, 2'd2, 8'h08, 1'b0, 0, "rev0001");
        do_op(1'b0, 8'h07, 2'd3, 8'h01, 1'b0, 0, "par0111");
        do_op(1'b0, 8'h0F, 2'd0, 8'h04, 1'b0, 0, "pop1111");
        do_op(1'b0, 8'h06, 2'd1, 8'h01, 1'b0, 0, "ffs0110");
        do_op(1'b0, 8'h0D, 2'd2, 8'h0B, 1'b0, 0, "rev1101");
        do_op(1'b0, 8'h00, 2'd3, 8'h00, 1'b1, 0, "par0000");
        do_op(1'b0, 8'h05, 2'd0, 8'h02, 1'b0, 5, "backpressure");

        // Abort an operation with reset during its second RUN cycle.
        check("abort in_ready", 8'(in_ready4), 8'd1);
        drive_in(1'b0, 1'b1, 8'h0B, 2'd0);
        @(posedge clk); #1;
        drive_in(1'b0, 1'b0, 8'h00, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort in_ready4",  8'(in_ready4),  8'd1);
        check("abort out_valid4", 8'(out_valid4), 8'd0);
        check("abort out_data4",  {4'h0, out_data4}, 8'h00);
        check("abort out_zero4",  8'(out_zero4),  8'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort no result", 8'(out_valid4), 8'd0);
        end
        do_op(1'b0, 8'h0E, 2'd1, 8'h01, 1'b0, 0, "post_rst");

        do_op(1'b1, 8'hA0, 2'd1, 8'd5, 1'b0, 0, "ffs8_a0");
        do_op(1'b1, 8'h01, 2'd2, 8'h80, 1'b0, 0, "rev8_01");
        for (int m = 0; m < 4; m++) begin
            for (int d = 0; d < 256; d++) begin
                do_op(1'b1, 8'(d), 2'(m), ref_res(8'(d), 2'(m), 8), (d == 0),
                      0, $sformatf("sweep m%0d d%02h", m, d));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
